// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable controller.
//   state_e           : controller states (HALT, RUN, STEP, SWITCH)
//   *_DEF             : default T-cycle dividers and speed-switch stall length
//   CNT_W / STALL_W   : widths of the prescaler and stall counters
//   is_active()       : true in the states where the CPU is being clocked
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_SWITCH = 2'd3
  } state_e;

  localparam int DIV_NORMAL_DEF   = 24;
  localparam int DIV_DOUBLE_DEF   = 12;
  localparam int SWITCH_STALL_DEF = 8;

  localparam int CNT_W   = 8;
  localparam int STALL_W = 8;

  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Prescaler producing a one-clk tick every `limit` clk cycles.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   en    : count enable; tick can only fire while en is high
//   clr   : synchronous clear, holds the count at 0
//   limit : divide ratio (cycles per tick), sampled every cycle
//   tick  : combinational, high when the count sits at limit-1 and en is high
module clk_prescaler
  import cpu_clk_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == (limit - CNT_W'(1)));
  assign tick   = en && at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_end ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller. Generates T-cycle and M-cycle enables from the
// 100 MHz system clock (no derived clocks), supports free-run, single M-cycle
// stepping and a stalled normal/double speed switch.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   run_req       : level, free-run the CPU while high
//   step_req      : one-clk pulse, run one M-cycle from HALT
//   speed_sw_req  : one-clk pulse, request a speed toggle
//   t_en, m_en    : one-clk T-cycle / M-cycle enables
//   t_phase       : T-cycle index within the M-cycle
//   double_speed  : current speed mode
//   running       : state is RUN or STEP
//   sw_busy       : state is SWITCH
//   step_done     : one-clk pulse on the M-cycle that ends a STEP
//   state         : current FSM state, for observation
// Inputs carry no handshake: run_req is sampled as a level every clk, the two
// request pulses are sampled for exactly the clk in which they are high.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_NORMAL   = DIV_NORMAL_DEF,
  parameter int DIV_DOUBLE   = DIV_DOUBLE_DEF,
  parameter int SWITCH_STALL = SWITCH_STALL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_req,
  input  logic       step_req,
  input  logic       speed_sw_req,
  output logic       t_en,
  output logic       m_en,
  output logic [1:0] t_phase,
  output logic       double_speed,
  output logic       running,
  output logic       sw_busy,
  output logic       step_done,
  output state_e     state
);

  logic               sw_pend;
  logic [STALL_W-1:0] stall;
  logic [CNT_W-1:0]   limit;
  logic               active;

  // Speed change only takes effect when leaving SWITCH, where the prescaler
  // is held cleared, so the divider never changes mid T-cycle.
  assign limit  = double_speed ? CNT_W'(DIV_DOUBLE) : CNT_W'(DIV_NORMAL);
  assign active = is_active(state);

  clk_prescaler u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active),
    .clr   (!active),
    .limit (limit),
    .tick  (t_en)
  );

  assign m_en      = t_en && (t_phase == 2'd3);
  assign step_done = m_en && (state == ST_STEP);
  assign running   = active;
  assign sw_busy   = (state == ST_SWITCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HALT;
      t_phase      <= 2'd0;
      stall        <= '0;
      sw_pend      <= 1'b0;
      double_speed <= 1'b0;
    end else begin
      if (t_en) begin
        t_phase <= t_phase + 2'd1;
      end

      // Requests arriving outside SWITCH are remembered until the switch runs.
      if (speed_sw_req && (state != ST_SWITCH)) begin
        sw_pend <= 1'b1;
      end

      case (state)
        ST_HALT: begin
          if (sw_pend || speed_sw_req) begin
            state <= ST_SWITCH;
          end else if (run_req) begin
            state <= ST_RUN;
          end else if (step_req) begin
            state <= ST_STEP;
          end
        end

        // Leave RUN only on an M-cycle boundary; a pending switch passes
        // through HALT first, which then moves on to SWITCH.
        ST_RUN: begin
          if (m_en && (sw_pend || !run_req)) begin
            state <= ST_HALT;
          end
        end

        ST_STEP: begin
          if (m_en) begin
            state <= ST_HALT;
          end
        end

        ST_SWITCH: begin
          if (stall == STALL_W'(SWITCH_STALL - 1)) begin
            stall        <= '0;
            double_speed <= !double_speed;
            sw_pend      <= 1'b0;
            state        <= ST_HALT;
          end else begin
            stall <= stall + STALL_W'(1);
          end
        end

        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule
